// File: rtl/ram_bus_pkg.sv
// Shared types and defaults for the sysbus RAM initiator.
package ram_bus_pkg;
  localparam int WORD_W_DEF = 8;
  localparam int OP_W_DEF   = 3;
  localparam int MAP_LO_DEF = 22;
  localparam int MAP_HI_DEF = 29;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, ACCESS, RDRV, RESP} state_t;

  // Address bits are what is left of a bus word after the opcode field.
  function automatic int addr_w(input int word_w, input int op_w);
    return word_w - op_w;
  endfunction
endpackage

// File: rtl/ram_bus_master_if.sv
// Client request/response channel plus RAM strobes of the sysbus initiator.
interface ram_bus_master_if
  import ram_bus_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OP_W   = OP_W_DEF
);
  localparam int AW = addr_w(WORD_W, OP_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              load_MAR;
  logic              load_MDR;
  logic              CS;
  logic              R_NW;
  logic              MDR_bus;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output load_MAR, load_MDR, CS, R_NW, MDR_bus
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  load_MAR, load_MDR, CS, R_NW, MDR_bus
  );
endinterface

// File: rtl/ram_bus_master.sv
// Sysbus RAM initiator: one request at a time, strobes sequenced by a Moore FSM,
// out-of-window addresses answered with an error and no bus activity.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int MAP_LO = MAP_LO_DEF,
  parameter int MAP_HI = MAP_HI_DEF
) (
  input  logic                clock,
  input  logic                reset,
  ram_bus_master_if.master    bus,
  inout  wire  [WORD_W-1:0]   sysbus
);
   localparam int AW = addr_w(WORD_W, OP_W);
   localparam logic [AW-1:0] LO = AW'(MAP_LO);
   localparam logic [AW-1:0] HI = AW'(MAP_HI);

   state_t            state, state_nx;
   logic              wr_q, err_q;
   logic [AW-1:0]     addr_q;
   logic [WORD_W-1:0] wdata_q, rdata_q;
   logic              accept, in_win;
   logic              drv_en;
   logic [WORD_W-1:0] drv_data;
   logic              ld_mar, ld_mdr, cs, rnw, mdr_bus;

   assign accept = bus.req_valid && (state == IDLE);
   assign in_win = (bus.req_addr >= LO) && (bus.req_addr <= HI);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Request fields are frozen at acceptance; later req_* changes are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         wr_q    <= bus.req_write;
         err_q   <= ~in_win;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         rdata_q <= '0;
      end else if (state == RDRV) begin
         rdata_q <= sysbus;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = in_win ? ADDR : RESP;
         ADDR:    state_nx = wr_q ? WDATA : ACCESS;
         WDATA:   state_nx = ACCESS;
         ACCESS:  state_nx = wr_q ? RESP : RDRV;
         RDRV:    state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ld_mar   = 1'b0;
      ld_mdr   = 1'b0;
      cs       = 1'b0;
      rnw      = 1'b0;
      mdr_bus  = 1'b0;
      drv_en   = 1'b0;
      drv_data = '0;
      case (state)
         ADDR: begin
            ld_mar   = 1'b1;
            drv_en   = 1'b1;
            drv_data = {{OP_W{1'b0}}, addr_q};
         end
         WDATA: begin
            ld_mdr   = 1'b1;
            drv_en   = 1'b1;
            drv_data = wdata_q;
         end
         ACCESS: begin
            cs  = 1'b1;
            rnw = ~wr_q;
         end
         RDRV:    mdr_bus = 1'b1;
         default: ;
      endcase
   end

   // Only ADDR and WDATA drive the bus, so MDR_bus never overlaps our driver.
   assign sysbus = drv_en ? drv_data : {WORD_W{1'bz}};

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.load_MAR  = ld_mar;
   assign bus.load_MDR  = ld_mdr;
   assign bus.CS        = cs;
   assign bus.R_NW      = rnw;
   assign bus.MDR_bus   = mdr_bus;
endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: RAM model on the sysbus, per-cycle reference model,
// directed literal cases followed by 200 randomized requests.
module tb_ram_bus_master;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  wire  [7:0] sysbus;

  ram_bus_master_if #(.WORD_W(8), .OP_W(3)) bus ();

  ram_bus_master dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .sysbus (sysbus)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0, n_acc = 0, viol = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Power-up RAM contents: an address-derived pattern.
  function automatic logic [7:0] pat(input int a);
    return 8'(a * 37 + 5);
  endfunction

  // ---------------- RAM on the sysbus ----------------
  logic [7:0] ram_mem [32];
  logic [31:0] ram_wr = '0;
  logic [4:0] mar;
  logic [7:0] mdr;

  assign sysbus = bus.MDR_bus ? mdr : 8'bz;

  always @(posedge clock) begin
    if (bus.load_MAR) mar <= sysbus[4:0];
    if (bus.load_MDR) mdr <= sysbus;
    if (bus.CS && bus.R_NW) mdr <= ram_wr[mar] ? ram_mem[mar] : pat(int'(mar));
    if (bus.CS && !bus.R_NW) begin
      ram_mem[mar] <= mdr;
      ram_wr[mar]  <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Transaction view: after acceptance, cycle k of the request shows a fixed
  // strobe pattern, then the response is held until rsp_ready.
  logic [7:0]  m_mem [32];
  logic [31:0] m_wr = '0;
  logic        busy = 1'b0, m_write;
  logic [4:0]  m_addr;
  logic [7:0]  m_wdata;
  int          k;
  logic [3:0]  stb;
  assign stb = {bus.load_MAR, bus.load_MDR, bus.CS, bus.MDR_bus};

  function automatic logic [7:0] mval(input logic [4:0] a);
    return m_wr[a] ? m_mem[a] : pat(int'(a));
  endfunction

  always @(negedge clock) begin
    logic       win, e_v, e_err, e_rnw, bchk;
    logic [3:0] e_stb;
    logic [7:0] e_rd, e_bus;
    if ($countones(stb) > 1) viol++;
    if (reset) begin
      busy = 1'b0;
      chk("rst_strobes", 32'(stb), 0);
      chk("rst_rnw", 32'(bus.R_NW), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 0);
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    end else begin
      win = (m_addr >= 5'd22) && (m_addr <= 5'd29);
      e_v = 0; e_err = 0; e_rnw = 0; bchk = 0; e_stb = 0; e_rd = 0; e_bus = 0;
      if (busy) begin
        if (!win) begin
          e_v = 1; e_err = 1;
        end else if (k >= 4) begin
          e_v = 1;
          e_rd = m_write ? 8'h00 : mval(m_addr);
        end else if (k == 1) begin
          e_stb = 4'b1000; bchk = 1; e_bus = {3'b000, m_addr};
        end else if (m_write && k == 2) begin
          e_stb = 4'b0100; bchk = 1; e_bus = m_wdata;
        end else if (m_write) begin
          e_stb = 4'b0010;
        end else if (k == 2) begin
          e_stb = 4'b0010; e_rnw = 1;
        end else begin
          e_stb = 4'b0001; bchk = 1; e_bus = mval(m_addr);
        end
      end
      chk("req_ready", 32'(bus.req_ready), 32'(!busy));
      chk("strobes", 32'(stb), 32'(e_stb));
      chk("R_NW", 32'(bus.R_NW), 32'(e_rnw));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_v));
      if (e_v) begin
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rd));
      end
      if (bchk) chk("sysbus", 32'(sysbus), 32'(e_bus));
      // advance to the state seen at the next negedge
      if (!busy) begin
        if (bus.req_valid) begin
          busy = 1'b1; k = 1; n_acc++;
          m_write = bus.req_write; m_addr = bus.req_addr; m_wdata = bus.req_wdata;
        end
      end else if (e_v) begin
        if (bus.rsp_ready) begin
          busy = 1'b0;
          if (m_write && win) begin
            m_mem[m_addr] = m_wdata;
            m_wr[m_addr]  = 1'b1;
          end
        end
      end else begin
        k++;
      end
    end
  end

  // ---------------- directed transaction ----------------
  // lat counts edges from the cycle the request is presented (the accepting
  // edge is edge 1); tr[i] holds the strobes seen after edge i+1.
  task automatic xact(input logic w, input logic [4:0] a, input logic [7:0] d,
                      input int hold, output logic [7:0] rd, output logic er,
                      output int lat, output logic [3:0][3:0] tr);
    @(posedge clock); #1;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    bus.rsp_ready = (hold == 0);
    tr = '0; lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) begin
        // mutate the request right after acceptance
        bus.req_valid = 1'b0; bus.req_addr = ~a; bus.req_wdata = ~d; bus.req_write = ~w;
      end
      if (lat <= 4) tr[lat-1] = stb;
    end while (!bus.rsp_valid && lat < 20);
    if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
    rd = bus.rsp_rdata; er = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rdata", 32'(bus.rsp_rdata), 32'(rd));
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("idle_after_rsp", 32'(bus.req_ready), 1);
  endtask

  initial begin
    logic [7:0]       rd;
    logic             er;
    int               lat, acc0, cyc;
    logic [3:0][3:0]  tr;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.rsp_ready = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_req_ready", 32'(bus.req_ready), 1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);

    // write 0xA5 to 22: MAR, MDR, CS in consecutive cycles
    xact(1, 5'd22, 8'hA5, 0, rd, er, lat, tr);
    chk("wr22_lat", lat, 4);
    chk("wr22_trace", 32'(tr[2:0]), 32'({4'b0010, 4'b0100, 4'b1000}));
    chk("wr22_err", 32'(er), 0);
    chk("wr22_rdata", 32'(rd), 0);

    xact(0, 5'd22, 8'h00, 0, rd, er, lat, tr);
    chk("rd22_lat", lat, 4);
    chk("rd22_data", 32'(rd), 32'h A5);
    chk("rd22_err", 32'(er), 0);
    chk("rd22_trace", 32'(tr[2:0]), 32'({4'b0001, 4'b0010, 4'b1000}));

    // upper boundary, never written: 29*37+5 = 1078 -> 0x36
    xact(0, 5'd29, 8'h00, 0, rd, er, lat, tr);
    chk("rd29_data", 32'(rd), 32'h36);
    chk("rd29_err", 32'(er), 0);

    xact(0, 5'd30, 8'h00, 0, rd, er, lat, tr);
    chk("rd30_err", 32'(er), 1);
    chk("rd30_rdata", 32'(rd), 0);
    chk("rd30_lat", lat, 1);
    chk("rd30_nostrobe", 32'(tr[0]), 0);

    xact(1, 5'd21, 8'h77, 0, rd, er, lat, tr);
    chk("wr21_err", 32'(er), 1);
    chk("wr21_lat", lat, 1);

    xact(0, 5'd21, 8'h00, 0, rd, er, lat, tr);
    chk("rd21_err", 32'(er), 1);
    chk("rd21_rdata", 32'(rd), 0);

    // backpressure for 5 cycles
    xact(0, 5'd22, 8'h00, 5, rd, er, lat, tr);
    chk("bp_data", 32'(rd), 32'hA5);

    // mutated request: accepted values must win
    xact(1, 5'd25, 8'h3C, 0, rd, er, lat, tr);
    xact(0, 5'd25, 8'h00, 0, rd, er, lat, tr);
    chk("mut_rd25", 32'(rd), 32'h3C);

    // reset asserted while in ADDR aborts the read with no response
    @(posedge clock); #1;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 5'd23; bus.rsp_ready = 1;
    @(posedge clock); #1;
    bus.req_valid = 0;
    chk("abort_in_addr", 32'(stb), 32'b1000);
    reset = 1'b1;
    #1;
    chk("abort_strobes", 32'(stb), 0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clock); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("abort_no_rsp", 32'(bus.rsp_valid), 0);
      chk("abort_req_ready", 32'(bus.req_ready), 1);
    end

    // randomized traffic, request fields change every cycle
    acc0 = n_acc; cyc = 0;
    while (n_acc < acc0 + 200 && cyc < 20000) begin
      @(posedge clock); #1;
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_write = $urandom_range(0, 1) != 0;
      bus.req_addr  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(20, 31));
      bus.req_wdata = 8'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("random_done", 32'(n_acc >= acc0 + 200), 1);
    bus.req_valid = 0; bus.rsp_ready = 1;
    repeat (8) @(posedge clock);
    #1;
    chk("strobe_overlap", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
